// File: rtl/rf_window_sequencer.sv
// rf_window_sequencer: walks the receptive-field selector through every output
// row and both column halves for one feature-map pass. Each window goes to the
// conv units over a valid/ready handshake, with the number of windows in flight
// capped at MAX_OUT. Returned results are tagged with their window index.
module rf_window_sequencer #(
  parameter int H       = 16,
  parameter int W       = 16,
  parameter int F       = 5,
  parameter int MAX_OUT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic [5:0] rowNumber,
  output logic       column,
  output logic       rf_valid,
  input  logic       rf_ready,
  input  logic       res_valid,
  output logic       res_we,
  output logic [5:0] res_addr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int R = H - F + 1;
  localparam int N = 2 * R;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] LAST_W  = 6'(N - 1);
  localparam logic [2:0] CAP     = 3'(MAX_OUT);

  // Reject geometries the 6-bit window index or 3-bit in-flight counter cannot hold.
  if (R < 1 || N > 64 || W < F || MAX_OUT < 1 || MAX_OUT > 4) begin : g_bad_params
    $error("rf_window_sequencer: illegal H/W/F/MAX_OUT combination");
  end

  logic [1:0] state;
  logic [5:0] w;
  logic [5:0] ridx;
  logic [2:0] outstanding;
  logic [2:0] out_nxt;
  logic [5:0] w_inc;
  logic       hs;
  logic       acc;
  logic       go;
  logic       clr;

  assign rf_valid = (state == S_ISSUE) && (outstanding < CAP);
  assign hs       = rf_valid & rf_ready;
  assign acc      = res_valid & (outstanding != 3'd0);
  assign go       = (state == S_IDLE) & start & ~abort;
  assign clr      = (state != S_IDLE) & abort;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign w_inc    = w + 6'd1;

  // In-flight count after this cycle's issue and return; a simultaneous pair cancels.
  always_comb begin
    out_nxt = outstanding;
    case ({hs, acc})
      2'b10:   out_nxt = outstanding + 3'd1;
      2'b01:   out_nxt = outstanding - 3'd1;
      default: out_nxt = outstanding;
    endcase
  end

  // Pass state machine: issue all windows, wait for results, pulse done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (go) state <= S_ISSUE;
        S_ISSUE: if (hs && (w == LAST_W)) state <= S_DRAIN;
        S_DRAIN: if (out_nxt == 3'd0) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Issue index, result index and in-flight counter; all restart on start or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w           <= '0;
      ridx        <= '0;
      outstanding <= '0;
    end else if (clr || go) begin
      w           <= '0;
      ridx        <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= out_nxt;
      if (hs)  w    <= w_inc;
      if (acc) ridx <= ridx + 6'd1;
    end
  end

  // Selector coordinates are registered so they hold once the last window has gone out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rowNumber <= '0;
      column    <= 1'b0;
    end else if (go) begin
      rowNumber <= '0;
      column    <= 1'b0;
    end else if (hs && (w != LAST_W) && !clr) begin
      rowNumber <= {1'b0, w_inc[5:1]};
      column    <= w_inc[0];
    end
  end

  // Result write strobe and tag; a result in the abort cycle is still written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_we   <= 1'b0;
      res_addr <= '0;
    end else begin
      res_we <= acc;
      if (acc) res_addr <= ridx;
    end
  end

  // Sticky error for a result arriving with nothing in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (go) begin
      err <= 1'b0;
    end else if (res_valid && (outstanding == 3'd0)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_window_sequencer.sv
// Directed bench for rf_window_sequencer at default geometry (R=12, N=24, MAX_OUT=2).
module tb_rf_window_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] rowNumber;
  logic       column;
  logic       rf_valid;
  logic       rf_ready = 1'b0;
  logic       res_valid = 1'b0;
  logic       res_we;
  logic [5:0] res_addr;
  logic       busy;
  logic       done;
  logic       err;

  int nvec = 0;
  int nerr = 0;

  rf_window_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .rowNumber (rowNumber),
    .column    (column),
    .rf_valid  (rf_valid),
    .rf_ready  (rf_ready),
    .res_valid (res_valid),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete pass: rf_ready high except an optional stall at window stall_idx,
  // each result returned 3 cycles after its window issued.
  task automatic run_pass(input int stall_idx, input int stall_len, input string tag);
    int iss_t[$];
    int issued, returned, dones, stalled, cyc, dummy;
    issued = 0; returned = 0; dones = 0; stalled = 0; cyc = 0;
    res_valid = 1'b0;
    rf_ready  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_at_start"}, busy, 1);
    chk({tag, "_err_cleared"}, err, 0);
    chk({tag, "_valid_at_start"}, rf_valid, 1);
    while (dones == 0 && cyc < 400) begin
      rf_ready  = 1'b1;
      res_valid = 1'b0;
      if (rf_valid) begin
        chk({tag, "_row"}, rowNumber, issued >> 1);
        chk({tag, "_col"}, column, issued & 1);
        if (issued == stall_idx && stalled < stall_len) begin
          rf_ready = 1'b0;
          stalled++;
        end else begin
          iss_t.push_back(cyc);
          issued++;
        end
      end
      if (iss_t.size() > 0 && iss_t[0] + 3 <= cyc) begin
        res_valid = 1'b1;
        dummy = iss_t.pop_front();
      end
      if (res_we) begin
        chk({tag, "_res_addr"}, res_addr, returned);
        returned++;
      end
      if (done) begin
        dones++;
        chk({tag, "_busy_in_done"}, busy, 1);
      end
      step();
      cyc++;
    end
    rf_ready  = 1'b0;
    res_valid = 1'b0;
    chk({tag, "_issued"}, issued, 24);
    chk({tag, "_returned"}, returned, 24);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_stall_cycles"}, stalled, (stall_idx >= 0) ? stall_len : 0);
    chk({tag, "_idle_after"}, busy, 0);
    chk({tag, "_valid_after"}, rf_valid, 0);
    chk({tag, "_err_after"}, err, 0);
    chk({tag, "_row_hold"}, rowNumber, 11);
    chk({tag, "_col_hold"}, column, 1);
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_row", rowNumber, 0);
    chk("rst_col", column, 0);
    chk("rst_valid", rf_valid, 0);
    chk("rst_we", res_we, 0);
    chk("rst_addr", res_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    step();
    reset_n = 1'b1;
    step();

    // Full pass without stall, then with a 4-cycle stall at window (5,1)
    run_pass(-1, 0, "full");
    run_pass(11, 4, "stall");

    // Outstanding cap and simultaneous issue/return
    rf_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cap_w0_valid", rf_valid, 1);
    step();
    chk("cap_w1_valid", rf_valid, 1);
    chk("cap_w1_col", column, 1);
    step();
    chk("cap_full_valid", rf_valid, 0);
    chk("cap_full_row", rowNumber, 1);
    chk("cap_full_col", column, 0);
    step();
    chk("cap_held_valid", rf_valid, 0);
    res_valid = 1'b1;
    step();
    chk("cap_ret_valid", rf_valid, 1);
    chk("cap_ret_row", rowNumber, 1);
    chk("cap_ret_col", column, 0);
    chk("cap_ret_we", res_we, 1);
    chk("cap_ret_addr", res_addr, 0);
    step();
    chk("simul_valid", rf_valid, 1);
    chk("simul_row", rowNumber, 1);
    chk("simul_col", column, 1);
    chk("simul_addr", res_addr, 1);
    res_valid = 1'b0;
    step();
    chk("cap2_valid", rf_valid, 0);
    chk("cap2_row", rowNumber, 2);
    chk("cap2_we", res_we, 0);
    rf_ready  = 1'b0;
    res_valid = 1'b1;
    step();
    chk("cap2_ret_valid", rf_valid, 1);
    chk("cap2_ret_addr", res_addr, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    res_valid = 1'b0;
    chk("abort_issue_busy", busy, 0);
    chk("abort_issue_valid", rf_valid, 0);
    chk("abort_issue_done", done, 0);
    chk("abort_issue_we", res_we, 1);
    chk("abort_issue_addr", res_addr, 3);
    chk("abort_issue_err", err, 0);

    // Abort in DRAIN with one result outstanding
    rf_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk("drn_valid", rf_valid, 1);
      chk("drn_row", rowNumber, k >> 1);
      chk("drn_col", column, k & 1);
      res_valid = (k > 0);
      step();
    end
    res_valid = 1'b0;
    rf_ready  = 1'b0;
    chk("drn_busy", busy, 1);
    chk("drn_valid_low", rf_valid, 0);
    chk("drn_row_hold", rowNumber, 11);
    chk("drn_col_hold", column, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_drn_busy", busy, 0);
    chk("abort_drn_done", done, 0);
    chk("abort_drn_valid", rf_valid, 0);
    step();
    chk("abort_drn_done2", done, 0);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("late_res_we", res_we, 0);
    chk("late_res_err", err, 1);
    step();
    chk("late_err_sticky", err, 1);
    chk("late_we2", res_we, 0);
    run_pass(-1, 0, "after_abort");

    // Reset mid-pass at window 10
    rf_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      res_valid = (k > 0);
      step();
    end
    chk("pre_rst_row", rowNumber, 5);
    chk("pre_rst_valid", rf_valid, 1);
    chk("pre_rst_we", res_we, 1);
    reset_n   = 1'b0;
    res_valid = 1'b0;
    rf_ready  = 1'b0;
    #1;
    chk("mid_rst_row", rowNumber, 0);
    chk("mid_rst_col", column, 0);
    chk("mid_rst_valid", rf_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", res_we, 0);
    chk("mid_rst_addr", res_addr, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    step();
    reset_n = 1'b1;
    step();
    run_pass(-1, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
